// File: rtl/register_bank.sv
// Eight-entry general-purpose register bank with a shared write bus and
// per-register write enables; every register is visible on its own output.
module register_bank #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            en,
   input  logic [DATA_WIDTH-1:0] to_dest_reg,
   output logic [DATA_WIDTH-1:0] q0,
   output logic [DATA_WIDTH-1:0] q1,
   output logic [DATA_WIDTH-1:0] q2,
   output logic [DATA_WIDTH-1:0] q3,
   output logic [DATA_WIDTH-1:0] q4,
   output logic [DATA_WIDTH-1:0] q5,
   output logic [DATA_WIDTH-1:0] q6,
   output logic [DATA_WIDTH-1:0] q7
);

   logic [DATA_WIDTH-1:0] regs_q [8];
   logic [DATA_WIDTH-1:0] regs_d [8];

   // Multi-hot enables are legal: every selected entry takes the same bus value.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         regs_d[i] = en[i] ? to_dest_reg : regs_q[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (rst) begin
            regs_q[i] <= '0;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign q0 = regs_q[0];
   assign q1 = regs_q[1];
   assign q2 = regs_q[2];
   assign q3 = regs_q[3];
   assign q4 = regs_q[4];
   assign q5 = regs_q[5];
   assign q6 = regs_q[6];
   assign q7 = regs_q[7];

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reset, single/walking/multi-hot writes,
// hold, boundary data, overwrite and mid-sequence reset.
module tb_register_bank;

   localparam int unsigned DW = 16;

   logic          clk;
   logic          rst;
   logic [7:0]    en;
   logic [DW-1:0] to_dest_reg;
   logic [DW-1:0] q [8];
   logic [DW-1:0] exp_q [8];

   int check_count = 0;
   int pass_count  = 0;

   register_bank #(.DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .to_dest_reg (to_dest_reg),
      .q0          (q[0]),
      .q1          (q[1]),
      .q2          (q[2]),
      .q3          (q[3]),
      .q4          (q[4]),
      .q5          (q[5]),
      .q6          (q[6]),
      .q7          (q[7])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic r, input logic [7:0] e, input logic [DW-1:0] d);
      @(negedge clk);
      rst         = r;
      en          = e;
      to_dest_reg = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      check_count++;
      assert (obs === expv) pass_count++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s q%0d", tag, i), q[i], exp_q[i]);
      end
   endtask

   initial begin
      rst = 1'b1;
      en = 8'h00;
      to_dest_reg = '0;

      // Reset wins over a full write.
      step(1'b1, 8'hFF, 16'hABCD);
      step(1'b1, 8'hFF, 16'hABCD);
      for (int i = 0; i < 8; i++) exp_q[i] = 16'h0000;
      check_all("reset");

      // Single writes on consecutive cycles.
      step(1'b0, 8'b0000_0001, 16'h0000);
      check_all("single0");
      step(1'b0, 8'b0000_0010, 16'h0001);
      exp_q[1] = 16'h0001;
      check_all("single1");

      // Walk all indices, checking each write is visible right after its edge.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'(1 << i), 16'(16'h1000 + i));
         check($sformatf("walk q%0d", i), q[i], 16'(16'h1000 + i));
      end
      exp_q[0] = 16'h1000; exp_q[1] = 16'h1001; exp_q[2] = 16'h1002; exp_q[3] = 16'h1003;
      exp_q[4] = 16'h1004; exp_q[5] = 16'h1005; exp_q[6] = 16'h1006; exp_q[7] = 16'h1007;
      check_all("walk");

      // en = 0 holds everything regardless of the bus.
      for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 16'hFFFF);
      check_all("hold");

      // Multi-hot write.
      step(1'b0, 8'b1010_0101, 16'h5A5A);
      exp_q[0] = 16'h5A5A; exp_q[2] = 16'h5A5A; exp_q[5] = 16'h5A5A; exp_q[7] = 16'h5A5A;
      check_all("multi");

      // Boundary data and back-to-back overwrite of R3.
      step(1'b0, 8'b0000_1000, 16'hFFFF);
      exp_q[3] = 16'hFFFF;
      check_all("max3");
      step(1'b0, 8'b0000_1000, 16'h0000);
      exp_q[3] = 16'h0000;
      check_all("zero3");

      // Load nonzero everywhere, then reset with a concurrent full write.
      step(1'b0, 8'hFF, 16'hC3C3);
      for (int i = 0; i < 8; i++) exp_q[i] = 16'hC3C3;
      check_all("preload");
      step(1'b1, 8'hFF, 16'h1234);
      for (int i = 0; i < 8; i++) exp_q[i] = 16'h0000;
      check_all("midreset");

      // First edge after reset deasserts accepts writes again.
      step(1'b0, 8'b0100_0000, 16'h0042);
      exp_q[6] = 16'h0042;
      check_all("postreset");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, required finish before 100000");
      $fatal(1);
   end

endmodule
